// File: rtl/fare_pkg.sv
// Shared types and constants for the fare ledger: table entry layout, FSM states, default fare.
package fare_pkg;

    localparam int ID_W         = 8;
    localparam int BAL_W        = 12;
    localparam int DATE_W       = 16;
    localparam int FARE_DEFAULT = 325;

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic              active;
        logic [BAL_W-1:0]  bal;
        logic [DATE_W-1:0] expiry;
    } ledger_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_RESP   = 2'd2,
        ST_DEDUCT = 2'd3
    } ledger_state_e;

endpackage

// File: rtl/fare_ledger_table.sv
// Register-held card table: one write port, two asynchronous read ports (search index, hit index).
module fare_ledger_table
    import fare_pkg::*;
#(
    parameter int NUM_CARDS = 8,
    parameter int IDX_W     = $clog2(NUM_CARDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [IDX_W-1:0] widx,
    input  ledger_entry_t wdata,
    input  logic [IDX_W-1:0] ridx_a,
    output ledger_entry_t rdata_a,
    input  logic [IDX_W-1:0] ridx_b,
    output ledger_entry_t rdata_b
);

    ledger_entry_t entries [NUM_CARDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CARDS; i++) begin
                entries[i] <= '0;
            end
        end else if (we) begin
            entries[widx] <= wdata;
        end
    end

    assign rdata_a = entries[ridx_a];
    assign rdata_b = entries[ridx_b];

endmodule

// File: rtl/fare_ledger.sv
// Account-side responder for the fare gate: linear card-table search, response flags, fare deduction.
// Optional balance top-up port set enabled by defining FARE_LEDGER_TOPUP_EN.
module fare_ledger
    import fare_pkg::*;
#(
    parameter int NUM_CARDS = 8,
    parameter int FARE      = FARE_DEFAULT,
    parameter int IDX_W     = $clog2(NUM_CARDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tap_valid,
    input  logic [ID_W-1:0]   tap_id,
    input  logic [DATE_W-1:0] today,
    input  logic              reduce_bal,
    output logic              resp_valid,
    output logic              card_active,
    output logic              fund_enough,
    output logic              monthly,
    output logic [BAL_W-1:0]  bal_out,
    output logic [DATE_W-1:0] expiry_out,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic              cfg_valid,
    input  logic              cfg_active,
    input  logic [ID_W-1:0]   cfg_id,
    input  logic [BAL_W-1:0]  cfg_bal,
    input  logic [DATE_W-1:0] cfg_expiry,
    output logic              cfg_busy,
    output ledger_state_e     dbg_state
`ifdef FARE_LEDGER_TOPUP_EN
    ,
    input  logic              topup_valid,
    input  logic [BAL_W-1:0]  topup_amt
`endif
);

    localparam logic [BAL_W-1:0] FARE_V = BAL_W'(FARE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CARDS - 1);

    ledger_state_e      state;
    logic [ID_W-1:0]    tap_id_q;
    logic [IDX_W-1:0]   idx, hit_idx, wr_idx;
    logic               hit, wr_en, in_resp, match, can_charge;
    ledger_entry_t      srch_e, hit_e, wr_e;

    fare_ledger_table #(.NUM_CARDS(NUM_CARDS), .IDX_W(IDX_W)) u_table (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wr_en),
        .widx   (wr_idx),
        .wdata  (wr_e),
        .ridx_a (idx),
        .rdata_a(srch_e),
        .ridx_b (hit_idx),
        .rdata_b(hit_e)
    );

    // Handshake: tap_valid is a one-cycle request accepted only in IDLE or RESP (no back-pressure);
    // resp_valid qualifies the flags for every cycle the FSM sits in RESP.
    assign in_resp     = (state == ST_RESP);
    assign match       = srch_e.valid && (srch_e.id == tap_id_q);
    assign resp_valid  = in_resp;
    assign card_active = in_resp && hit && hit_e.active;
    assign fund_enough = card_active && (hit_e.bal >= FARE_V);
    assign monthly     = card_active && (hit_e.expiry >= today);
    assign bal_out     = (in_resp && hit) ? hit_e.bal : '0;
    assign expiry_out  = (in_resp && hit) ? hit_e.expiry : '0;
    assign can_charge  = fund_enough && !monthly;
    assign cfg_busy    = (state != ST_IDLE);
    assign dbg_state   = state;

    logic unused_srch;
    assign unused_srch = ^{srch_e.active, srch_e.bal, srch_e.expiry};

`ifdef FARE_LEDGER_TOPUP_EN
    logic             topup_go;
    logic [BAL_W:0]   topup_sum;
    assign topup_go  = card_active && !reduce_bal && topup_valid;
    assign topup_sum = {1'b0, hit_e.bal} + {1'b0, topup_amt};
`endif

    // Single table write port: cfg in IDLE, deduction in DEDUCT, top-up in RESP.
    always_comb begin
        wr_en         = 1'b0;
        wr_idx        = cfg_idx;
        wr_e.valid    = cfg_valid;
        wr_e.id       = cfg_id;
        wr_e.active   = cfg_active;
        wr_e.bal      = cfg_bal;
        wr_e.expiry   = cfg_expiry;
        if (state == ST_IDLE && cfg_we) begin
            wr_en = 1'b1;
        end else if (state == ST_DEDUCT) begin
            wr_en    = 1'b1;
            wr_idx   = hit_idx;
            wr_e     = hit_e;
            wr_e.bal = hit_e.bal - FARE_V;
        end
`ifdef FARE_LEDGER_TOPUP_EN
        else if (topup_go) begin
            wr_en    = 1'b1;
            wr_idx   = hit_idx;
            wr_e     = hit_e;
            wr_e.bal = topup_sum[BAL_W] ? '1 : topup_sum[BAL_W-1:0];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tap_id_q <= '0;
            idx      <= '0;
            hit_idx  <= '0;
            hit      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!cfg_we && tap_valid) begin
                        tap_id_q <= tap_id;
                        idx      <= '0;
                        hit      <= 1'b0;
                        state    <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (match) begin
                        hit     <= 1'b1;
                        hit_idx <= idx;
                        state   <= ST_RESP;
                    end else if (idx == LAST_IDX) begin
                        hit   <= 1'b0;
                        state <= ST_RESP;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_RESP: begin
                    // A reduce_bal pulse always shadows a same-cycle tap, even when it is refused.
                    if (reduce_bal) begin
                        if (can_charge) state <= ST_DEDUCT;
                    end else if (tap_valid) begin
                        tap_id_q <= tap_id;
                        idx      <= '0;
                        hit      <= 1'b0;
                        state    <= ST_SEARCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fare_ledger.sv
// Directed testbench for fare_ledger (NUM_CARDS=8, FARE=325); top-up vectors when FARE_LEDGER_TOPUP_EN is set.
module tb_fare_ledger;
    import fare_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tap_valid = 1'b0;
    logic [ID_W-1:0]   tap_id = '0;
    logic [DATE_W-1:0] today = '0;
    logic              reduce_bal = 1'b0;
    logic              resp_valid, card_active, fund_enough, monthly;
    logic [BAL_W-1:0]  bal_out;
    logic [DATE_W-1:0] expiry_out;
    logic              cfg_we = 1'b0;
    logic [2:0]        cfg_idx = '0;
    logic              cfg_valid = 1'b0;
    logic              cfg_active = 1'b0;
    logic [ID_W-1:0]   cfg_id = '0;
    logic [BAL_W-1:0]  cfg_bal = '0;
    logic [DATE_W-1:0] cfg_expiry = '0;
    logic              cfg_busy;
    ledger_state_e     dbg_state;
`ifdef FARE_LEDGER_TOPUP_EN
    logic              topup_valid = 1'b0;
    logic [BAL_W-1:0]  topup_amt = '0;
`endif

    int checks = 0;
    int failures = 0;

    fare_ledger #(.NUM_CARDS(8), .FARE(325)) dut (
        .clk(clk), .rst_n(rst_n), .tap_valid(tap_valid), .tap_id(tap_id), .today(today),
        .reduce_bal(reduce_bal), .resp_valid(resp_valid), .card_active(card_active),
        .fund_enough(fund_enough), .monthly(monthly), .bal_out(bal_out), .expiry_out(expiry_out),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid), .cfg_active(cfg_active),
        .cfg_id(cfg_id), .cfg_bal(cfg_bal), .cfg_expiry(cfg_expiry), .cfg_busy(cfg_busy),
        .dbg_state(dbg_state)
`ifdef FARE_LEDGER_TOPUP_EN
        , .topup_valid(topup_valid), .topup_amt(topup_amt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tap_valid = 1'b0; reduce_bal = 1'b0; cfg_we = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic cfg_write(input int idx, input logic act, input int id, input int bal, input int exp_day);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_valid = 1'b1; cfg_active = act;
        cfg_id = ID_W'(id); cfg_bal = BAL_W'(bal); cfg_expiry = DATE_W'(exp_day);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic do_tap(input int id);
        tap_valid = 1'b1; tap_id = ID_W'(id);
        step();
        tap_valid = 1'b0;
    endtask

    // Returns the edge count after the tap edge until resp_valid rises (bounded).
    task automatic wait_resp(output int n);
        n = 0;
        while (!resp_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    int n;

    initial begin
        today = 16'd200;
        rst_n = 1'b0;
        #2;
        // 1. reset state and miss on an empty table
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_busy", 32'(cfg_busy), 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_bal", 32'(bal_out), 0);
        do_reset();
        do_tap(8'h2A);
        wait_resp(n);
        check("miss_cycle", 32'(n + 1), 9);
        check("miss_active", 32'(card_active), 0);
        check("miss_fund", 32'(fund_enough), 0);
        check("miss_monthly", 32'(monthly), 0);
        check("miss_bal", 32'(bal_out), 0);

        // 2. hit at entry 3 (duplicate at 5 must lose), deduct with a shadowed tap
        do_reset();
        cfg_write(3, 1'b1, 8'h2A, 1000, 100);
        cfg_write(5, 1'b1, 8'h2A, 50, 100);
        do_tap(8'h2A);
        wait_resp(n);
        check("hit_cycle", 32'(n + 1), 5);
        check("hit_active", 32'(card_active), 1);
        check("hit_fund", 32'(fund_enough), 1);
        check("hit_monthly", 32'(monthly), 0);
        check("hit_bal", 32'(bal_out), 1000);
        check("hit_expiry", 32'(expiry_out), 100);
        reduce_bal = 1'b1; tap_valid = 1'b1; tap_id = 8'h55;
        step();
        reduce_bal = 1'b0; tap_valid = 1'b0;
        check("deduct_state", 32'(dbg_state), 32'(ST_DEDUCT));
        check("deduct_resp", 32'(resp_valid), 0);
        step();
        check("after_deduct_state", 32'(dbg_state), 32'(ST_IDLE));
        do_tap(8'h2A);
        wait_resp(n);
        check("deducted_bal", 32'(bal_out), 675);

        // 3. insufficient funds: reduce ignored; then re-tap from RESP hits entry 1
        do_reset();
        cfg_write(3, 1'b1, 8'h2A, 300, 100);
        cfg_write(1, 1'b1, 8'h2B, 777, 100);
        do_tap(8'h2A);
        wait_resp(n);
        check("low_fund", 32'(fund_enough), 0);
        check("low_active", 32'(card_active), 1);
        reduce_bal = 1'b1;
        step();
        reduce_bal = 1'b0;
        check("low_state", 32'(dbg_state), 32'(ST_RESP));
        check("low_bal", 32'(bal_out), 300);
        do_tap(8'h2B);
        check("retap_state", 32'(dbg_state), 32'(ST_SEARCH));
        wait_resp(n);
        check("retap_cycle", 32'(n + 1), 3);
        check("retap_bal", 32'(bal_out), 777);

        // 4. monthly boundary: expiry == today is valid, no charge; then expiry passes
        do_reset();
        cfg_write(3, 1'b1, 8'h2A, 1000, 200);
        today = 16'd200;
        do_tap(8'h2A);
        wait_resp(n);
        check("mon_monthly", 32'(monthly), 1);
        reduce_bal = 1'b1;
        step();
        reduce_bal = 1'b0;
        check("mon_state", 32'(dbg_state), 32'(ST_RESP));
        check("mon_bal", 32'(bal_out), 1000);
        today = 16'd201;
        step();
        check("expired_monthly", 32'(monthly), 0);
        check("expired_fund", 32'(fund_enough), 1);

        // 5. cfg_we ignored while busy; asynchronous reset mid-search clears table
        do_reset();
        today = 16'd200;
        cfg_write(0, 1'b1, 8'h10, 500, 300);
        do_tap(8'h77);
        check("busy_search", 32'(cfg_busy), 1);
        cfg_write(2, 1'b1, 8'h77, 900, 300);
        wait_resp(n);
        check("busy_nowrite_cycle", 32'(n + 2), 9);
        check("busy_nowrite_active", 32'(card_active), 0);
        do_tap(8'h77);
        step();
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("arst_resp", 32'(resp_valid), 0);
        check("arst_busy", 32'(cfg_busy), 0);
        step();
        rst_n = 1'b1;
        step();
        do_tap(8'h10);
        wait_resp(n);
        check("arst_table_cycle", 32'(n + 1), 9);
        check("arst_table_active", 32'(card_active), 0);

`ifdef FARE_LEDGER_TOPUP_EN
        // 6. top-up, plain and saturating
        do_reset();
        cfg_write(3, 1'b1, 8'h2A, 300, 100);
        do_tap(8'h2A);
        wait_resp(n);
        topup_valid = 1'b1; topup_amt = 12'd100;
        step();
        topup_valid = 1'b0;
        check("topup_bal", 32'(bal_out), 400);
        check("topup_fund", 32'(fund_enough), 1);
        do_reset();
        cfg_write(3, 1'b1, 8'h2A, 4000, 100);
        do_tap(8'h2A);
        wait_resp(n);
        topup_valid = 1'b1; topup_amt = 12'd500;
        step();
        topup_valid = 1'b0;
        check("topup_sat", 32'(bal_out), 4095);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
